// File: rtl/mmio_hub_if.sv
// Bus bundle for mmio_hub: CPU byte bus, RAM port, UART TX/RX streams and status flags.
// slave = hub side, master = CPU/RAM/UART environment side.
interface mmio_hub_if;
  logic [31:0] cpu_a;
  logic [7:0]  cpu_dout;
  logic        cpu_wr;
  logic [7:0]  cpu_din;
  logic        cpu_rdy;
  logic [16:0] ram_a;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        program_done;
  logic        tx_overflow;

  modport slave (
    input  cpu_a, cpu_dout, cpu_wr, ram_rdata, tx_ready, rx_data, rx_valid,
    output cpu_din, cpu_rdy, ram_a, ram_we, ram_wdata, tx_data, tx_valid,
    output rx_ready, program_done, tx_overflow
  );

  modport master (
    output cpu_a, cpu_dout, cpu_wr, ram_rdata, tx_ready, rx_data, rx_valid,
    input  cpu_din, cpu_rdy, ram_a, ram_we, ram_wdata, tx_data, tx_valid,
    input  rx_ready, program_done, tx_overflow
  );
endinterface

// File: rtl/mmio_hub.sv
// MMIO hub: decodes CPU byte accesses to RAM, UART FIFOs and the cycle counter / stop port.
// Optional MMIO_CLK_SNAPSHOT_EN: a read of 0x30004 latches the counter so 4-byte reads are coherent.
module mmio_hub #(
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 8
) (
  input  logic       clk_in,
  input  logic       rst_in,
  mmio_hub_if.slave  bus
);
  localparam int TXW = $clog2(TX_DEPTH);
  localparam int RXW = $clog2(RX_DEPTH);
  localparam logic [TXW:0] TX_FULL = (TXW+1)'(TX_DEPTH);
  localparam logic [TXW:0] TX_HWM  = (TXW+1)'(TX_DEPTH - 2);
  localparam logic [RXW:0] RX_FULL = (RXW+1)'(RX_DEPTH);

  typedef enum logic [2:0] {
    T_NONE = 3'd0, T_RAM = 3'd1, T_RX = 3'd2,
    T_CNT0 = 3'd3, T_CNT1 = 3'd4, T_CNT2 = 3'd5, T_CNT3 = 3'd6
  } target_e;

  logic [7:0]     tx_mem_r [TX_DEPTH];
  logic [TXW-1:0] tx_wp_r, tx_rp_r;
  logic [TXW:0]   tx_cnt_r, tx_cnt_next_s;
  logic [7:0]     rx_mem_r [RX_DEPTH];
  logic [RXW-1:0] rx_wp_r, rx_rp_r;
  logic [RXW:0]   rx_cnt_r, rx_cnt_next_s;
  logic [7:0]     rx_byte_r;
  logic [31:0]    cnt_r, cnt_src_s;
  logic           done_r, ovf_r, rdy_r;
  target_e        tgt_r, tgt_next_s;

  logic        io_sel_s, rd_s;
  logic [15:0] io_off_s;
  logic        tx_push_req_s, tx_push_s, tx_pop_s, tx_full_s, tx_drop_s, set_done_s;
  logic [7:0]  tx_push_data_s;
  logic        rx_push_s, rx_pop_s;
  logic        unused_s;

  assign unused_s = ^bus.cpu_a[31:18];
  assign io_sel_s = (bus.cpu_a[17:16] == 2'b11);
  assign io_off_s = bus.cpu_a[15:0];
  assign rd_s     = ~bus.cpu_wr;

  assign bus.ram_a     = bus.cpu_a[16:0];
  assign bus.ram_we    = bus.cpu_wr & ~io_sel_s;
  assign bus.ram_wdata = bus.cpu_dout;

  // TX push request decode; all IO writes are dead once the program has stopped
  always_comb begin
    tx_push_req_s  = 1'b0;
    tx_push_data_s = 8'h00;
    set_done_s     = 1'b0;
    if (io_sel_s && bus.cpu_wr && !done_r) begin
      if (io_off_s == 16'h0000) begin
        tx_push_req_s  = (bus.cpu_dout != 8'h00);
        tx_push_data_s = bus.cpu_dout;
      end else if (io_off_s == 16'h0004) begin
        tx_push_req_s = 1'b1;
        set_done_s    = 1'b1;
      end else begin
        tx_push_req_s = 1'b0;
      end
    end else begin
      tx_push_req_s = 1'b0;
    end
  end

  assign tx_full_s     = (tx_cnt_r == TX_FULL);
  assign tx_pop_s      = (tx_cnt_r != '0) & bus.tx_ready;
  assign tx_push_s     = tx_push_req_s & (~tx_full_s | tx_pop_s);
  assign tx_drop_s     = tx_push_req_s & tx_full_s & ~tx_pop_s;
  assign tx_cnt_next_s = tx_cnt_r + (TXW+1)'(tx_push_s) - (TXW+1)'(tx_pop_s);
  assign bus.tx_valid  = (tx_cnt_r != '0);
  assign bus.tx_data   = bus.tx_valid ? tx_mem_r[tx_rp_r] : 8'h00;

  assign bus.rx_ready  = (rx_cnt_r != RX_FULL);
  assign rx_push_s     = bus.rx_valid & bus.rx_ready;
  assign rx_pop_s      = io_sel_s & rd_s & (io_off_s == 16'h0000) & (rx_cnt_r != '0);
  assign rx_cnt_next_s = rx_cnt_r + (RXW+1)'(rx_push_s) - (RXW+1)'(rx_pop_s);

  // Read target for the data phase one cycle later
  always_comb begin
    tgt_next_s = T_NONE;
    if (!rd_s) begin
      tgt_next_s = T_NONE;
    end else if (!io_sel_s) begin
      tgt_next_s = T_RAM;
    end else begin
      case (io_off_s)
        16'h0000: tgt_next_s = (rx_cnt_r != '0) ? T_RX : T_NONE;
        16'h0004: tgt_next_s = T_CNT0;
        16'h0005: tgt_next_s = T_CNT1;
        16'h0006: tgt_next_s = T_CNT2;
        16'h0007: tgt_next_s = T_CNT3;
        default:  tgt_next_s = T_NONE;
      endcase
    end
  end

`ifdef MMIO_CLK_SNAPSHOT_EN
  logic [31:0] snap_r;
  // Counter snapshot taken by the byte-0 read
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)                  snap_r <= 32'h0000_0000;
    else if (tgt_next_s == T_CNT0) snap_r <= cnt_r;
    else                          snap_r <= snap_r;
  end
  assign cnt_src_s = snap_r;
`else
  assign cnt_src_s = cnt_r;
`endif

  // Read data mux driven from the registered target
  always_comb begin
    case (tgt_r)
      T_RAM:   bus.cpu_din = bus.ram_rdata;
      T_RX:    bus.cpu_din = rx_byte_r;
      T_CNT0:  bus.cpu_din = cnt_src_s[7:0];
      T_CNT1:  bus.cpu_din = cnt_src_s[15:8];
      T_CNT2:  bus.cpu_din = cnt_src_s[23:16];
      T_CNT3:  bus.cpu_din = cnt_src_s[31:24];
      default: bus.cpu_din = 8'h00;
    endcase
  end

  assign bus.cpu_rdy      = rdy_r;
  assign bus.program_done = done_r;
  assign bus.tx_overflow  = ovf_r;

  // FIFO storage (no reset needed; occupancy gates every use)
  always_ff @(posedge clk_in) begin
    if (tx_push_s) tx_mem_r[tx_wp_r] <= tx_push_data_s;
    if (rx_push_s) rx_mem_r[rx_wp_r] <= bus.rx_data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      tx_wp_r  <= '0;
      tx_rp_r  <= '0;
      tx_cnt_r <= '0;
      rx_wp_r  <= '0;
      rx_rp_r  <= '0;
      rx_cnt_r <= '0;
    end else begin
      tx_wp_r  <= tx_push_s ? tx_wp_r + TXW'(1) : tx_wp_r;
      tx_rp_r  <= tx_pop_s  ? tx_rp_r + TXW'(1) : tx_rp_r;
      tx_cnt_r <= tx_cnt_next_s;
      rx_wp_r  <= rx_push_s ? rx_wp_r + RXW'(1) : rx_wp_r;
      rx_rp_r  <= rx_pop_s  ? rx_rp_r + RXW'(1) : rx_rp_r;
      rx_cnt_r <= rx_cnt_next_s;
    end
  end

  // Read pipeline, counter, flags; two slots of headroom cover the write already in flight
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      tgt_r     <= T_NONE;
      rx_byte_r <= 8'h00;
      cnt_r     <= 32'h0000_0000;
      done_r    <= 1'b0;
      ovf_r     <= 1'b0;
      rdy_r     <= 1'b1;
    end else begin
      tgt_r     <= tgt_next_s;
      rx_byte_r <= rx_pop_s ? rx_mem_r[rx_rp_r] : rx_byte_r;
      cnt_r     <= cnt_r + 32'd1;
      done_r    <= done_r | set_done_s;
      ovf_r     <= ovf_r | tx_drop_s;
      rdy_r     <= (tx_cnt_next_s < TX_HWM);
    end
  end
endmodule

// File: doc/mmio_hub.md
Name: mmio_hub

Overview:
- Sits directly downstream of the CPU core's external byte bus (address, data out, write strobe, data in) and drives its ready input.
- Decodes each access to one of three targets:
  - RAM at 0x00000–0x1FFFF.
  - UART byte port at 0x30000.
  - Cycle counter / program-stop port at 0x30004–0x30007.
- Buffers the UART TX and RX streams in FIFOs.
- Deasserts CPU ready when the TX FIFO nears full.

Parameters:
- TX_DEPTH, 16, TX FIFO entries; power of two, minimum 4.
- RX_DEPTH, 8, RX FIFO entries; power of two, minimum 2.

Ports:
- clk_in  input  1  system clock; the only clock.
- rst_in  input  1  asynchronous, active-low reset.
- cpu_a  input  32  CPU address; only [17:0] decoded.
- cpu_dout  input  8  CPU write data.
- cpu_wr  input  1  1 = write, 0 = read (every cycle is an access).
- cpu_din  output  8  read data returned to the CPU.
- cpu_rdy  output  1  ready to the CPU; low pauses the CPU.
- ram_a  output  17  RAM address.
- ram_we  output  1  RAM write enable.
- ram_wdata  output  8  RAM write data.
- ram_rdata  input  8  RAM read data, synchronous, valid the cycle after the address.
- tx_data  output  8  UART TX byte.
- tx_valid  output  1  TX FIFO non-empty.
- tx_ready  input  1  UART accepts tx_data this cycle.
- rx_data  input  8  UART RX byte.
- rx_valid  input  1  RX byte offered.
- rx_ready  output  1  RX FIFO not full.
- program_done  output  1  sticky; set by a write to 0x30004.
- tx_overflow  output  1  sticky; a TX push was dropped because the FIFO was full.

Behaviour:
- Reset values: all outputs 0, FIFOs empty, counter 0, program_done 0, tx_overflow 0. Exceptions: cpu_rdy = 1 and rx_ready = 1 once reset is released.
- Decode:
  - cpu_a[17:16] == 2'b11 selects IO; otherwise RAM.
  - RAM outputs are combinational pass-through: ram_a = cpu_a[16:0], ram_we = cpu_wr & RAM, ram_wdata = cpu_dout.
- Read latency: 1 cycle (the CPU's two-cycle read).
  - On a read in cycle N, register the target (RAM, RX, CNT0..CNT3, NONE) in cycle N.
  - cpu_din in cycle N+1 is muxed from that registered target.
  - Writes return no data; target becomes NONE.
- RX read at 0x30000:
  - Non-empty: pops one byte, returned in N+1.
  - Empty: returns 0x00, no pop.
  - Push (rx_valid & rx_ready) and pop in the same cycle are both honoured; a full FIFO then stays full.
- Counter:
  - 32-bit free-running, +1 every clock after reset, wraps 0xFFFFFFFF -> 0.
  - Read 0x30004+k returns byte k, little-endian.
- TX writes:
  - Write to 0x30000 with non-zero data pushes the byte; data 0x00 is ignored.
  - Write to 0x30004 sets program_done and pushes 0x00.
  - Push to a full FIFO is dropped and sets tx_overflow.
  - Push and pop (tx_valid & tx_ready) in the same cycle are both honoured, including when full.
- After program_done: all IO writes are ignored; RAM access is unaffected.
- cpu_rdy:
  - Registered.
  - Next value = (TX occupancy after this cycle's push/pop) < TX_DEPTH-2.
  - The two slots of headroom absorb the in-flight write.
- Other IO addresses (0x30001–0x30003, 0x30008 and up): reads return 0x00; writes ignored.
- Reset asserted mid-operation: all state clears at once; a pending read returns 0x00.
- Address [31:18] ignored; no range check above 0x1FFFF within RAM space; ram_a wraps.

Optional Feature:
- MMIO_CLK_SNAPSHOT_EN:
  - Defined: a read of 0x30004 returns counter byte 0 and latches the full 32-bit counter into a snapshot register. Reads of 0x30005–0x30007 return bytes from the snapshot, so a 4-byte sequence is coherent.
  - Not defined: every byte is read from the live counter.

Test Plan:
- Reset release, 5 clocks, then read 0x30004..0x30007 on consecutive cycles.
  - Without the macro: bytes 0x05, 0x00, 0x00, 0x00 (±1 per cycle on byte 0).
  - With the macro: all bytes come from the value latched at the 0x30004 read.
- Write 0x41 then 0x00 to 0x30000 with tx_ready=0 -> one TX entry, tx_data=0x41, tx_valid=1.
- 14 writes of 0x55 to 0x30000 with tx_ready=0, TX_DEPTH=16 -> cpu_rdy falls the cycle after occupancy reaches 14. A forced 17th push sets tx_overflow=1 and leaves occupancy at 16.
- RX receives 0x12 then 0x34; read 0x30000 three times -> cpu_din = 0x12, 0x34, 0x00, each one cycle after its address.
- RAM write 0xAB to 0x00010, then read 0x00010 -> ram_we pulses with ram_a=0x0010, and cpu_din=0xAB the next cycle.
- Write to 0x30004 -> program_done=1 and 0x00 is queued. A following write of 0x42 to 0x30000 is ignored. Asserting rst_in low clears program_done.
